fsic_coreclk_tx_framer: RTL and testbench
=========================================

// Module: fsic_coreclk_tx_framer
// PURPOSE
// - Coreclk-domain TX framer feeding the io_serdes serializer: packs one AXIS beat per coreclk into a parallel tx_word.
// - The ioclk serializer slices tx_word by the ioclk phase count; phase k drives bits [k*pSERIALIO_WIDTH +: pSERIALIO_WIDTH].
// - Owns link bring-up (training words), idle insertion and credit-style backpressure from the remote receiver.
// PARAMETERS
// - pSERIALIO_WIDTH  12  serial lanes per direction
// - pCLK_RATIO       4   ioclk cycles per coreclk; tx_word width W = pSERIALIO_WIDTH*pCLK_RATIO (48)
// - pDATA_WIDTH      32  AXIS tdata width; tkeep width = pDATA_WIDTH/8
// - pUSER_WIDTH      2   AXIS tuser width
// - pTRAIN_CYCLES    16  coreclk cycles of training pattern; legal range 1..255
// - Elaboration check: W >= pDATA_WIDTH + pDATA_WIDTH/8 + pUSER_WIDTH + 3
// PORTS
// - coreclk          in   1    core clock; all logic on posedge
// - axis_rst_n       in   1    reset, asynchronous, active-low
// - txen             in   1    link enable from config; low forces IDLE
// - s_axis_tdata     in   pDATA_WIDTH    beat data
// - s_axis_tkeep     in   pDATA_WIDTH/8  byte keep
// - s_axis_tuser     in   pUSER_WIDTH    sideband
// - s_axis_tlast     in   1    end of packet
// - s_axis_tvalid    in   1    beat valid
// - s_axis_tready    out  1    beat accepted when tvalid&tready at posedge
// - remote_rx_ready  in   1    peer receiver has space (decoded by local RX path)
// - local_rx_ready   in   1    our receiver has space; advertised to peer in every RUN word
// - tx_word          out  W    registered parallel word to serializer
// - tx_train_done    out  1    high in RUN
// - tx_beat_cnt      out  16   count of data beats sent; wraps 0xFFFF->0
// BEHAVIOUR
// - Reset: state=IDLE, tx_word=0, s_axis_tready=0, tx_train_done=0, tx_beat_cnt=0, FIFO empty, train counter=0.
// - Reset asserted mid-operation: all of the above in the same instant; FIFO contents are lost.
// - Word layout (RUN): [pDATA_WIDTH-1:0] tdata; next pDATA_WIDTH/8 bits tkeep; next pUSER_WIDTH bits tuser;
//   then tlast, then VALID, then RDY (=local_rx_ready); remaining upper bits 0. For defaults: tlast=38, VALID=39, RDY=40.
// - FSM states and transitions (registered):
//   IDLE : txen=1 -> TRAIN with train counter=0; tx_word=0.
//   TRAIN: tx_word = {W/2{2'b10}} (0xAAAA_AAAA_AAAA for defaults); counter++ each cycle;
//          counter==pTRAIN_CYCLES-1 -> RUN.
//   RUN  : data/idle words as below; tx_train_done=1.
//   Any state: txen=0 -> IDLE next edge and FIFO flushed; tx_word=0 from that edge.
// - 2-entry FIFO between AXIS and tx_word; s_axis_tready = (state==RUN) && (count<2), decoded from registered state/count.
// - Pop on an edge when state==RUN && remote_rx_ready && count>0: tx_word <= packed head with VALID=1; tx_beat_cnt++.
// - Otherwise in RUN: idle word, tx_word <= all zero except RDY=local_rx_ready.
// - Latency: beat accepted at edge k is at the FIFO head after edge k and is loaded into tx_word no earlier than edge k+1.
// - Simultaneous push+pop: count unchanged, order preserved. No push at count==2 (tready=0).
// - remote_rx_ready low: beats held, never dropped or duplicated; at most 2 beats buffered.
// - tx_word changes only at coreclk edges; it is stable for all pCLK_RATIO ioclk phases.
// STRUCTURE
// - Package fsic_serdes_pkg: field offsets (VALID/RDY/tlast positions), training pattern function of W, FSM state
//   encoding {IDLE, TRAIN, RUN}, and the width elaboration check.
// - Sub-module fsic_tx_skid_fifo: 2-entry register FIFO (push/pop/count/flush) carrying {tdata,tkeep,tuser,tlast}.
// - Top: FSM, train counter, packing mux, beat counter, tready decode.
// TESTING
// - Reset then txen=1: 16 words of 0xAAAA_AAAA_AAAA, then tx_train_done=1 and tready=1 in the next cycle.
// - RUN, remote_rx_ready=1, beats 0x11111111..0x44444444 with tkeep=0xF, tlast on 4th -> four VALID words in order,
//   bit38 set only on the 4th word, tx_beat_cnt=4.
// - remote_rx_ready=0, 3 beats offered -> 2 accepted, tready=0, idle words only; ready=1 -> 3 beats emitted in order.
// - local_rx_ready toggled in RUN with no traffic -> idle words with bit40 tracking it, VALID=0, all other bits 0.
// - txen dropped with 2 beats buffered -> IDLE next edge, tx_word=0, FIFO empty; txen=1 -> full 16-cycle retrain.
// - Async reset asserted mid-packet -> all outputs to reset values immediately; force tx_beat_cnt to 0xFFFF, send 1 beat -> 0.

Source files
------------

// File: rtl/fsic_serdes_pkg.sv
// Shared definitions for the coreclk TX framer: word field offsets, training pattern,
// FSM encoding and the word-width sanity check.
package fsic_serdes_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TRAIN = 2'd1,
      ST_RUN   = 2'd2
   } tx_state_e;

   localparam int TRAIN_MAX_W = 256;

   // Control bits sit directly above the packed {tlast,tuser,tkeep,tdata} payload.
   function automatic int tlast_pos(input int dw, input int uw);
      return dw + dw / 8 + uw;
   endfunction

   function automatic int valid_pos(input int dw, input int uw);
      return tlast_pos(dw, uw) + 1;
   endfunction

   function automatic int rdy_pos(input int dw, input int uw);
      return tlast_pos(dw, uw) + 2;
   endfunction

   function automatic bit width_ok(input int w, input int dw, input int uw);
      return w >= dw + dw / 8 + uw + 3;
   endfunction

   function automatic logic [TRAIN_MAX_W-1:0] train_pattern(input int w);
      logic [TRAIN_MAX_W-1:0] p;
      p = '0;
      for (int i = 1; i < w && i < TRAIN_MAX_W; i += 2) begin
         p[i] = 1'b1;
      end
      return p;
   endfunction

endpackage

// File: rtl/fsic_tx_skid_fifo.sv
// Two-entry register FIFO; entry 0 is always the head. Push at count 2 and pop at
// count 0 are excluded by the caller; flush empties it and wins over push/pop.
module fsic_tx_skid_fifo #(
   parameter int DW = 39
) (
   input  logic          coreclk,
   input  logic          axis_rst_n,
   input  logic          flush_i,
   input  logic          push_i,
   input  logic [DW-1:0] push_dat_i,
   input  logic          pop_i,
   output logic [DW-1:0] head_dat_o,
   output logic [1:0]    count_o
);

   logic [DW-1:0] ent0_q;
   logic [DW-1:0] ent1_q;
   logic [1:0]    cnt_q;

   always_ff @(posedge coreclk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         ent0_q <= '0;
         ent1_q <= '0;
         cnt_q  <= 2'd0;
      end else if (flush_i) begin
         cnt_q <= 2'd0;
      end else begin
         case ({push_i, pop_i})
            2'b10: begin
               if (cnt_q == 2'd0) ent0_q <= push_dat_i;
               else               ent1_q <= push_dat_i;
               cnt_q <= cnt_q + 2'd1;
            end
            2'b01: begin
               ent0_q <= ent1_q;
               cnt_q  <= cnt_q - 2'd1;
            end
            2'b11: begin
               // Count stays put; the new beat lands behind whatever remains.
               if (cnt_q == 2'd1) begin
                  ent0_q <= push_dat_i;
               end else begin
                  ent0_q <= ent1_q;
                  ent1_q <= push_dat_i;
               end
            end
            default: ;
         endcase
      end
   end

   assign head_dat_o = ent0_q;
   assign count_o    = cnt_q;

endmodule

// File: rtl/fsic_coreclk_tx_framer.sv
// Coreclk TX framer: trains the link, then packs one buffered AXIS beat per cycle into
// tx_word (registered, one-cycle min latency) gated by remote_rx_ready; tready drops at 2 buffered.
module fsic_coreclk_tx_framer
   import fsic_serdes_pkg::*;
#(
   parameter int pSERIALIO_WIDTH = 12,
   parameter int pCLK_RATIO      = 4,
   parameter int pDATA_WIDTH     = 32,
   parameter int pUSER_WIDTH     = 2,
   parameter int pTRAIN_CYCLES   = 16
) (
   input  logic                                  coreclk,
   input  logic                                  axis_rst_n,
   input  logic                                  txen,
   input  logic [pDATA_WIDTH-1:0]                s_axis_tdata,
   input  logic [pDATA_WIDTH/8-1:0]              s_axis_tkeep,
   input  logic [pUSER_WIDTH-1:0]                s_axis_tuser,
   input  logic                                  s_axis_tlast,
   input  logic                                  s_axis_tvalid,
   output logic                                  s_axis_tready,
   input  logic                                  remote_rx_ready,
   input  logic                                  local_rx_ready,
   output logic [pSERIALIO_WIDTH*pCLK_RATIO-1:0] tx_word,
   output logic                                  tx_train_done,
   output logic [15:0]                           tx_beat_cnt
);

   localparam int W       = pSERIALIO_WIDTH * pCLK_RATIO;
   localparam int FW      = pDATA_WIDTH + pDATA_WIDTH / 8 + pUSER_WIDTH + 1;
   localparam int VLD_POS = valid_pos(pDATA_WIDTH, pUSER_WIDTH);
   localparam int RDY_POS = rdy_pos(pDATA_WIDTH, pUSER_WIDTH);
   localparam logic [W-1:0] TRAIN_WORD = W'(train_pattern(W));
   localparam logic [7:0]   TRAIN_LAST = 8'(pTRAIN_CYCLES - 1);

   if (!width_ok(W, pDATA_WIDTH, pUSER_WIDTH)) begin : g_bad_width
      $error("tx_word too narrow for payload plus control bits");
   end
   if (pTRAIN_CYCLES < 1 || pTRAIN_CYCLES > 255) begin : g_bad_train
      $error("pTRAIN_CYCLES must be 1..255");
   end

   tx_state_e     state_q, state_d;
   logic [7:0]    train_cnt_q, train_cnt_d;
   logic [W-1:0]  tx_word_q, tx_word_d;
   logic [15:0]   beat_cnt_q;
   logic [1:0]    fifo_cnt;
   logic [FW-1:0] fifo_head;
   logic          push;
   logic          pop;

   assign s_axis_tready = (state_q == ST_RUN) && (fifo_cnt != 2'd2);
   assign push          = s_axis_tvalid && s_axis_tready;

   fsic_tx_skid_fifo #(.DW(FW)) u_fifo (
      .coreclk    (coreclk),
      .axis_rst_n (axis_rst_n),
      .flush_i    (!txen),
      .push_i     (push),
      .push_dat_i ({s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata}),
      .pop_i      (pop),
      .head_dat_o (fifo_head),
      .count_o    (fifo_cnt)
   );

   // tx_word is loaded from the state being entered, so it lines up with state_q.
   always_comb begin
      state_d     = state_q;
      train_cnt_d = train_cnt_q;
      tx_word_d   = '0;
      pop         = 1'b0;
      if (!txen) begin
         state_d     = ST_IDLE;
         train_cnt_d = 8'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d     = ST_TRAIN;
               train_cnt_d = 8'd0;
               tx_word_d   = TRAIN_WORD;
            end
            ST_TRAIN: begin
               if (train_cnt_q == TRAIN_LAST) begin
                  state_d            = ST_RUN;
                  tx_word_d[RDY_POS] = local_rx_ready;
               end else begin
                  train_cnt_d = train_cnt_q + 8'd1;
                  tx_word_d   = TRAIN_WORD;
               end
            end
            ST_RUN: begin
               if (remote_rx_ready && fifo_cnt != 2'd0) begin
                  pop                = 1'b1;
                  tx_word_d[FW-1:0]  = fifo_head;
                  tx_word_d[VLD_POS] = 1'b1;
               end
               tx_word_d[RDY_POS] = local_rx_ready;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge coreclk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         state_q     <= ST_IDLE;
         train_cnt_q <= 8'd0;
         tx_word_q   <= '0;
         beat_cnt_q  <= 16'd0;
      end else begin
         state_q     <= state_d;
         train_cnt_q <= train_cnt_d;
         tx_word_q   <= tx_word_d;
         if (pop) beat_cnt_q <= beat_cnt_q + 16'd1;
      end
   end

   assign tx_word       = tx_word_q;
   assign tx_train_done = (state_q == ST_RUN);
   assign tx_beat_cnt   = beat_cnt_q;

endmodule

// File: tb/tb_fsic_coreclk_tx_framer.sv
// Bench for fsic_coreclk_tx_framer: scoreboard model of the 2-deep buffer and word
// packing, plus tables for the 4-beat packet and local_rx_ready idle words.
module tb_fsic_coreclk_tx_framer;

   logic        coreclk = 1'b0;
   logic        axis_rst_n;
   logic        txen;
   logic [31:0] s_axis_tdata;
   logic [3:0]  s_axis_tkeep;
   logic [1:0]  s_axis_tuser;
   logic        s_axis_tlast;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic        remote_rx_ready;
   logic        local_rx_ready;
   logic [47:0] tx_word;
   logic        tx_train_done;
   logic [15:0] tx_beat_cnt;

   localparam logic [47:0] TRAIN_W = 48'hAAAA_AAAA_AAAA;
   localparam logic [47:0] RDY_BIT = 48'h0100_0000_0000;

   typedef struct {
      logic [31:0] d;
      logic [3:0]  k;
      logic [1:0]  u;
      logic        l;
      logic [47:0] exp;   // expected word without the RDY bit
   } sb_item_t;

   typedef struct {
      logic        loc;
      logic [47:0] exp;
   } idle_vec_t;

   sb_item_t    send_q[$];
   sb_item_t    exp_q[$];
   sb_item_t    pkt_tbl[4];
   idle_vec_t   idle_tbl[6];
   bit          mon_en;
   logic [15:0] bcnt_m;
   int          errors;
   int          checks;

   always #5 coreclk = ~coreclk;

   fsic_coreclk_tx_framer dut (
      .coreclk         (coreclk),
      .axis_rst_n      (axis_rst_n),
      .txen            (txen),
      .s_axis_tdata    (s_axis_tdata),
      .s_axis_tkeep    (s_axis_tkeep),
      .s_axis_tuser    (s_axis_tuser),
      .s_axis_tlast    (s_axis_tlast),
      .s_axis_tvalid   (s_axis_tvalid),
      .s_axis_tready   (s_axis_tready),
      .remote_rx_ready (remote_rx_ready),
      .local_rx_ready  (local_rx_ready),
      .tx_word         (tx_word),
      .tx_train_done   (tx_train_done),
      .tx_beat_cnt     (tx_beat_cnt)
   );

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic sb_item_t mk(input logic [31:0] d, input logic [3:0] k,
                                   input logic [1:0] u, input logic l);
      sb_item_t it;
      it.d   = d;
      it.k   = k;
      it.u   = u;
      it.l   = l;
      it.exp = {8'h00, 1'b1, l, u, k, d};
      return it;
   endfunction

   task automatic drive();
      s_axis_tvalid = (send_q.size() != 0);
      if (send_q.size() != 0) begin
         s_axis_tdata = send_q[0].d;
         s_axis_tkeep = send_q[0].k;
         s_axis_tuser = send_q[0].u;
         s_axis_tlast = send_q[0].l;
      end else begin
         s_axis_tdata = '0;
         s_axis_tkeep = '0;
         s_axis_tuser = '0;
         s_axis_tlast = 1'b0;
      end
   endtask

   // One edge; inputs still hold the values the DUT saw at that edge.
   task automatic tick();
      sb_item_t    e;
      bit          popped;
      bit          acc;
      logic [47:0] w_exp;
      @(posedge coreclk);
      #1;
      if (mon_en) begin
         popped = txen && remote_rx_ready && (exp_q.size() > 0);
         acc    = txen && s_axis_tvalid && (exp_q.size() < 2);
         w_exp  = txen ? (local_rx_ready ? RDY_BIT : 48'h0) : 48'h0;
         if (popped) begin
            e      = exp_q.pop_front();
            w_exp  = e.exp | w_exp;
            bcnt_m = bcnt_m + 16'd1;
         end
         if (acc) exp_q.push_back(send_q.pop_front());
         if (!txen) exp_q.delete();
         chk("sb_tx_word", tx_word, w_exp);
         chk("sb_beat_cnt", {32'h0, tx_beat_cnt}, {32'h0, bcnt_m});
         chk("sb_tready", {47'h0, s_axis_tready}, {47'h0, txen && (exp_q.size() < 2)});
      end
      drive();
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((send_q.size() != 0 || exp_q.size() != 0) && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (send_q.size() != 0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s: %0d beats still pending after 40 cycles, required 0", tag,
                  send_q.size() + exp_q.size());
      end
   endtask

   task automatic train_seq();
      for (int i = 0; i < 16; i++) begin
         tick();
         chk("train_word", tx_word, TRAIN_W);
         chk("train_done_low", {47'h0, tx_train_done}, 48'h0);
      end
      tick();
      chk("train_done", {47'h0, tx_train_done}, 48'h1);
      chk("run_tready", {47'h0, s_axis_tready}, 48'h1);
      chk("run_first_idle", tx_word, local_rx_ready ? RDY_BIT : 48'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      errors = 0;
      checks = 0;
      mon_en = 1'b0;
      bcnt_m = 16'd0;
      pkt_tbl[0] = '{32'h1111_1111, 4'hF, 2'd0, 1'b0, 48'h008F_1111_1111};
      pkt_tbl[1] = '{32'h2222_2222, 4'hF, 2'd1, 1'b0, 48'h009F_2222_2222};
      pkt_tbl[2] = '{32'h3333_3333, 4'hF, 2'd2, 1'b0, 48'h00AF_3333_3333};
      pkt_tbl[3] = '{32'h4444_4444, 4'hF, 2'd0, 1'b1, 48'h00CF_4444_4444};
      idle_tbl[0] = '{1'b0, 48'h0};
      idle_tbl[1] = '{1'b1, RDY_BIT};
      idle_tbl[2] = '{1'b0, 48'h0};
      idle_tbl[3] = '{1'b1, RDY_BIT};
      idle_tbl[4] = '{1'b1, RDY_BIT};
      idle_tbl[5] = '{1'b0, 48'h0};

      axis_rst_n      = 1'b0;
      txen            = 1'b0;
      remote_rx_ready = 1'b1;
      local_rx_ready  = 1'b1;
      drive();
      #3;
      chk("rst_tx_word", tx_word, 48'h0);
      chk("rst_tready", {47'h0, s_axis_tready}, 48'h0);
      chk("rst_done", {47'h0, tx_train_done}, 48'h0);
      chk("rst_beat_cnt", {32'h0, tx_beat_cnt}, 48'h0);

      @(negedge coreclk);
      axis_rst_n = 1'b1;
      txen       = 1'b1;
      train_seq();
      mon_en = 1'b1;

      // Four-beat packet from the table, remote ready throughout.
      for (int i = 0; i < 4; i++) send_q.push_back(pkt_tbl[i]);
      drive();
      drain("pkt4");
      chk("pkt4_beat_cnt", {32'h0, tx_beat_cnt}, 48'd4);

      // Remote stalled: only two of three beats can be held.
      remote_rx_ready = 1'b0;
      send_q.push_back(mk(32'hA5A5_0001, 4'h3, 2'd1, 1'b0));
      send_q.push_back(mk(32'hA5A5_0002, 4'hC, 2'd2, 1'b0));
      send_q.push_back(mk(32'hA5A5_0003, 4'h1, 2'd3, 1'b1));
      drive();
      for (int i = 0; i < 6; i++) tick();
      chk("stall_tready", {47'h0, s_axis_tready}, 48'h0);
      remote_rx_ready = 1'b1;
      drain("stall_release");

      // Idle words advertise local_rx_ready and nothing else.
      for (int i = 0; i < 6; i++) begin
         local_rx_ready = idle_tbl[i].loc;
         tick();
         chk("idle_tbl", tx_word, idle_tbl[i].exp);
      end
      local_rx_ready = 1'b1;

      // Drop txen with two beats buffered; they must never appear.
      remote_rx_ready = 1'b0;
      send_q.push_back(mk(32'hDEAD_0001, 4'hF, 2'd0, 1'b0));
      send_q.push_back(mk(32'hDEAD_0002, 4'hF, 2'd0, 1'b1));
      drive();
      for (int i = 0; i < 4; i++) tick();
      txen = 1'b0;
      tick();
      mon_en = 1'b0;
      chk("drop_done", {47'h0, tx_train_done}, 48'h0);
      chk("drop_word", tx_word, 48'h0);
      tick();
      chk("idle_word_hold", tx_word, 48'h0);
      remote_rx_ready = 1'b1;
      txen            = 1'b1;
      train_seq();
      mon_en = 1'b1;
      for (int i = 0; i < 3; i++) tick();

      // Asynchronous reset in the middle of a packet.
      for (int i = 0; i < 4; i++) send_q.push_back(mk(32'h5000_0000 + i, 4'hF, 2'd0, i == 3));
      drive();
      tick();
      tick();
      mon_en = 1'b0;
      #2;
      axis_rst_n = 1'b0;
      #1;
      chk("arst_tx_word", tx_word, 48'h0);
      chk("arst_tready", {47'h0, s_axis_tready}, 48'h0);
      chk("arst_done", {47'h0, tx_train_done}, 48'h0);
      chk("arst_beat_cnt", {32'h0, tx_beat_cnt}, 48'h0);
      send_q.delete();
      exp_q.delete();
      drive();
      bcnt_m = 16'd0;
      @(negedge coreclk);
      axis_rst_n = 1'b1;
      train_seq();

      // Beat counter wrap.
      force dut.beat_cnt_q = 16'hFFFF;
      #1;
      release dut.beat_cnt_q;
      bcnt_m = 16'hFFFF;
      mon_en = 1'b1;
      send_q.push_back(mk(32'h0BAD_CAFE, 4'hF, 2'd0, 1'b1));
      drive();
      drain("wrap");
      chk("wrap_beat_cnt", {32'h0, tx_beat_cnt}, 48'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
